// File: rtl/mips_alu_pkg.sv
// Shared encodings for the branch/set-less-than condition unit: op codes, FSM
// states, and small decode helpers.
package mips_alu_pkg;

    typedef enum logic [2:0] {
        OpBeq  = 3'd0,
        OpBne  = 3'd1,
        OpBlez = 3'd2,
        OpBgtz = 3'd3,
        OpBltz = 3'd4,
        OpBgez = 3'd5,
        OpSlt  = 3'd6,
        OpSltu = 3'd7
    } cond_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } cmp_state_e;

    // Signed ops get bit 31 flipped so the byte scan can stay purely unsigned.
    function automatic logic op_is_signed(cond_op_e op);
        return (op == OpBlez) || (op == OpBgtz) || (op == OpBltz) ||
               (op == OpBgez) || (op == OpSlt);
    endfunction

    function automatic logic op_is_zero_cmp(cond_op_e op);
        return (op == OpBlez) || (op == OpBgtz) || (op == OpBltz) || (op == OpBgez);
    endfunction

    function automatic logic cond_taken(cond_op_e op, logic gt, logic eq, logic lt);
        logic t;
        t = 1'b0;
        case (op)
            OpBeq:   t = eq;
            OpBne:   t = !eq;
            OpBlez:  t = lt | eq;
            OpBgtz:  t = gt;
            OpBltz:  t = lt;
            OpBgez:  t = gt | eq;
            OpSlt:   t = lt;
            OpSltu:  t = lt;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/byte_cmp_cell.sv
// 8-bit unsigned magnitude comparator producing one-hot gt/eq/lt.
module byte_cmp_cell (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = a > b;
    assign eq = a == b;
    assign lt = a < b;

endmodule

// File: rtl/branch_cond_unit.sv
// Multi-cycle branch condition evaluator: scans operands one byte per cycle from
// the MSB and stops at the first differing byte.
module branch_cond_unit
    import mips_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        taken,
    output logic        a_gt_b,
    output logic        a_eq_b,
    output logic        a_lt_b
);

    cmp_state_e  state_q, state_d;
    cond_op_e    op_in;
    cond_op_e    op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] a_cap, b_cap;
    logic [1:0]  idx_q;
    logic        gt_q, eq_q, lt_q;
    logic [7:0]  a_byte, b_byte;
    logic        byte_gt, byte_eq, byte_lt;
    logic        accept;

    assign op_in  = cond_op_e'(op);
    assign accept = in_valid && (state_q == StIdle);

    always_comb begin
        a_cap = a;
        b_cap = op_is_zero_cmp(op_in) ? 32'd0 : b;
        if (op_is_signed(op_in)) begin
            a_cap[31] = ~a_cap[31];
            b_cap[31] = ~b_cap[31];
        end
    end

    assign a_byte = a_q[{idx_q, 3'b000} +: 8];
    assign b_byte = b_q[{idx_q, 3'b000} +: 8];

    byte_cmp_cell u_byte_cmp (
        .a  (a_byte),
        .b  (b_byte),
        .gt (byte_gt),
        .eq (byte_eq),
        .lt (byte_lt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (in_valid) state_d = StScan;
            StScan: if (!byte_eq || (idx_q == 2'd0)) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpBeq;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            idx_q   <= 2'd3;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q  <= op_in;
                        a_q   <= a_cap;
                        b_q   <= b_cap;
                        idx_q <= 2'd3;
                        gt_q  <= 1'b0;
                        eq_q  <= 1'b0;
                        lt_q  <= 1'b0;
                    end
                end
                StScan: begin
                    if (!byte_eq) begin
                        gt_q <= byte_gt;
                        lt_q <= byte_lt;
                        eq_q <= 1'b0;
                    end else if (idx_q == 2'd0) begin
                        eq_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 2'd1;
                    end
                end
                StDone: begin
                    // Flags return to zero as the result is consumed.
                    if (out_ready) begin
                        gt_q <= 1'b0;
                        eq_q <= 1'b0;
                        lt_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign taken     = out_valid && cond_taken(op_q, gt_q, eq_q, lt_q);
    assign a_gt_b    = gt_q;
    assign a_eq_b    = eq_q;
    assign a_lt_b    = lt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed and randomized checks for branch_cond_unit.
module tb_branch_cond_unit;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic        a_gt_b;
    logic        a_eq_b;
    logic        a_lt_b;

    int vectors = 0;
    int miscompares = 0;

    int   res_lat;
    logic res_taken;
    logic [2:0] res_flags;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic        tk;
        logic [2:0]  flags;  // {gt, eq, lt}
    } vec_t;

    always #5 clk = ~clk;

    branch_cond_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .a_gt_b    (a_gt_b),
        .a_eq_b    (a_eq_b),
        .a_lt_b    (a_lt_b)
    );

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge until out_valid; 99 marks a timeout.
    task automatic wait_result();
        res_lat = 0;
        while (!out_valid && res_lat < 20) begin
            @(posedge clk);
            #1;
            res_lat++;
        end
        if (!out_valid) res_lat = 99;
        res_taken = taken;
        res_flags = {a_gt_b, a_eq_b, a_lt_b};
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 3'd0;
        a = 32'd0;
        b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        vectors++;
        if ({out_valid, taken, a_gt_b, a_eq_b, a_lt_b} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 00000",
                     {out_valid, taken, a_gt_b, a_eq_b, a_lt_b});
        end
    endtask

    task automatic test_directed();
        vec_t v[$];
        v.push_back(vec_t'{3'd0, 32'h12345678, 32'h12345678, 4, 1'b1, 3'b010});
        v.push_back(vec_t'{3'd6, 32'hFFFFFFFF, 32'h00000001, 1, 1'b1, 3'b001});
        v.push_back(vec_t'{3'd7, 32'hFFFFFFFF, 32'h00000001, 1, 1'b0, 3'b100});
        v.push_back(vec_t'{3'd3, 32'h00000001, 32'hDEADBEEF, 4, 1'b1, 3'b100});
        v.push_back(vec_t'{3'd2, 32'h80000000, 32'h00000000, 1, 1'b1, 3'b001});
        v.push_back(vec_t'{3'd5, 32'h00000000, 32'hFFFFFFFF, 4, 1'b1, 3'b010});
        v.push_back(vec_t'{3'd4, 32'h7FFFFFFF, 32'h00000000, 1, 1'b0, 3'b100});
        v.push_back(vec_t'{3'd1, 32'h0000AB00, 32'h0000AC00, 3, 1'b1, 3'b001});
        v.push_back(vec_t'{3'd6, 32'h7FFFFFFF, 32'h80000000, 1, 1'b0, 3'b100});
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b);
            wait_result();
            vectors++;
            if (res_lat !== v[i].lat) begin
                miscompares++;
                $display("FAIL directed[%0d] latency got %0d want %0d", i, res_lat, v[i].lat);
            end
            vectors++;
            if (res_taken !== v[i].tk) begin
                miscompares++;
                $display("FAIL directed[%0d] taken got %b want %b", i, res_taken, v[i].tk);
            end
            vectors++;
            if (res_flags !== v[i].flags) begin
                miscompares++;
                $display("FAIL directed[%0d] flags gt/eq/lt got %b want %b",
                         i, res_flags, v[i].flags);
            end
            retire();
        end
    endtask

    task automatic test_backpressure();
        issue(3'd1, 32'h000000FF, 32'h000000FE);
        wait_result();
        vectors++;
        if (res_lat !== 4) begin
            miscompares++;
            $display("FAIL bp_latency got %0d want 4", res_lat);
        end
        // A competing request during DONE must be ignored.
        in_valid = 1'b1;
        op = 3'd0;
        a = 32'd0;
        b = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({out_valid, taken, a_gt_b, a_eq_b, a_lt_b, in_ready} !== 6'b111000) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] valid/taken/gt/eq/lt/in_ready got %b want 111000",
                         i, {out_valid, taken, a_gt_b, a_eq_b, a_lt_b, in_ready});
            end
        end
        in_valid = 1'b0;
        retire();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release valid/in_ready got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_mid_scan_reset();
        int seen;
        issue(3'd0, 32'h12345678, 32'h12345678);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_scan valid/in_ready got %b want 01", {out_valid, in_ready});
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_scan_no_result got %0d valid cycles want 0", seen);
        end
        issue(3'd1, 32'h00000001, 32'h00000002);
        wait_result();
        vectors++;
        if ({res_lat[3:0], res_taken, res_flags} !== {4'd4, 1'b1, 3'b001}) begin
            miscompares++;
            $display("FAIL rst_scan_next lat/taken/flags got %0d/%b/%b want 4/1/001",
                     res_lat, res_taken, res_flags);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] av, bv, bb;
        logic        lt, eq, gt, tk;
        logic [31:0] x;
        int          mode, lat;
        out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            o = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 4);
            av = $urandom;
            if (o >= 3'd2 && o <= 3'd5) begin
                if (mode == 4) av = 32'd0;
                else av = av >> (8 * mode);
                if ($urandom_range(0, 1) == 1) av[31] = 1'b1;
                bv = $urandom;
                bb = 32'd0;
            end else begin
                bv = av;
                if (mode < 4) bv = av ^ (32'($urandom_range(1, 255)) << (8 * mode));
                bb = bv;
            end
            if (o >= 3'd2 && o <= 3'd6) lt = $signed(av) < $signed(bb);
            else lt = av < bb;
            eq = (av == bb);
            gt = !lt && !eq;
            case (o)
                3'd0: tk = eq;
                3'd1: tk = !eq;
                3'd2: tk = lt || eq;
                3'd3: tk = gt;
                3'd4: tk = lt;
                3'd5: tk = gt || eq;
                default: tk = lt;
            endcase
            x = av ^ bb;
            if (x[31:24] != 0) lat = 1;
            else if (x[23:16] != 0) lat = 2;
            else if (x[15:8] != 0) lat = 3;
            else lat = 4;

            issue(o, av, bv);
            wait_result();
            vectors++;
            if (res_lat !== lat || res_taken !== tk || res_flags !== {gt, eq, lt}) begin
                miscompares++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h lat/taken/flags got %0d/%b/%b want %0d/%b/%b",
                         n, o, av, bv, res_lat, res_taken, res_flags, lat, tk, {gt, eq, lt});
            end
            @(posedge clk);
            #1;
            vectors++;
            if ({out_valid, in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL b2b[%0d] post_handshake valid/in_ready got %b want 01",
                         n, {out_valid, in_ready});
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_scan_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
